// File: rtl/ef_smsdac_pkg.sv
// rtl/ef_smsdac_pkg.sv - shared types and constants for the mismatch-shaping DAC controller
package ef_smsdac_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEED  = 2'd1,
    FLUSH = 2'd2,
    RUN   = 2'd3
  } state_t;

  localparam logic [1:0] MODE_OFF    = 2'b00;
  localparam logic [1:0] MODE_RAND   = 2'b01;
  localparam logic [1:0] MODE_TOGGLE = 2'b10;

  localparam int             LFSR_W            = 16;
  localparam logic [LFSR_W-1:0] LFSR_DEFAULT_SEED = 16'h0001;

  // Fibonacci taps for x^16 + x^14 + x^13 + x^11 + 1
  localparam int TAP_A = 15;
  localparam int TAP_B = 13;
  localparam int TAP_C = 12;
  localparam int TAP_D = 10;

  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] q);
    return {q[LFSR_W-2:0], q[TAP_A] ^ q[TAP_B] ^ q[TAP_C] ^ q[TAP_D]};
  endfunction

endpackage

// File: rtl/ef_smsdac_lfsr16.sv
// rtl/ef_smsdac_lfsr16.sv - 16-bit Fibonacci LFSR with seed load and zero-seed guard
module ef_smsdac_lfsr16
  import ef_smsdac_pkg::*;
(
  input  logic              clk,
  input  logic              rst_b,
  input  logic              load,
  input  logic [LFSR_W-1:0] seed,
  input  logic              adv,
  output logic [LFSR_W-1:0] q,
  output logic [LFSR_W-1:0] q_next
);

  assign q_next = lfsr_step(q);

  // An all-zero state would lock up, so a zero seed falls back to the default
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      q <= LFSR_DEFAULT_SEED;
    end else if (load) begin
      q <= (seed == '0) ? LFSR_DEFAULT_SEED : seed;
    end else if (adv) begin
      q <= q_next;
    end
  end

endmodule

// File: rtl/ef_smsdac_mse_ctrl.sv
// rtl/ef_smsdac_mse_ctrl.sv - sample timing, input handshake and r-bit generation for the MSE DAC
module ef_smsdac_mse_ctrl
  import ef_smsdac_pkg::*;
#(
  parameter int NSB   = 7,
  parameter int DW    = 4,
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             cfg_en,
  input  logic [1:0]       cfg_mode,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic [15:0]      cfg_seed,
  input  logic [DW-1:0]    din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic [DW-1:0]    dout,
  output logic [NSB-1:0]   r,
  output logic             sample_en,
  output logic             sb_rst_b,
  output logic             underflow
);

  state_t            state, state_nxt;
  logic              flush_cnt;
  logic [DIV_W-1:0]  div_cnt;
  logic              toggle;
  logic              slot;
  logic              transfer;
  logic [LFSR_W-1:0] lfsr_q, lfsr_q_next;
  logic              unused_lfsr;

  assign slot      = (state == RUN) && (div_cnt == '0);
  assign din_ready = slot;
  assign transfer  = din_valid & slot;

  ef_smsdac_lfsr16 u_lfsr (
    .clk    (clk),
    .rst_b  (rst_b),
    .load   (state == SEED),
    .seed   (cfg_seed),
    .adv    (slot),
    .q      (lfsr_q),
    .q_next (lfsr_q_next)
  );

  assign unused_lfsr = ^{lfsr_q, lfsr_q_next};

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = SEED;
      SEED:    state_nxt = FLUSH;
      FLUSH:   state_nxt = flush_cnt ? RUN : FLUSH;
      RUN:     state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
    if (!cfg_en) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state     <= IDLE;
      flush_cnt <= 1'b0;
      div_cnt   <= '0;
      toggle    <= 1'b0;
      dout      <= '0;
      r         <= '0;
      sample_en <= 1'b0;
      sb_rst_b  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      state     <= state_nxt;
      sb_rst_b  <= (state_nxt == RUN);
      sample_en <= slot && cfg_en;
      flush_cnt <= (state == FLUSH) ? ~flush_cnt : 1'b0;

      if (state == FLUSH && state_nxt == RUN) begin
        div_cnt <= cfg_div;
      end else if (state == RUN) begin
        div_cnt <= slot ? cfg_div : div_cnt - 1'b1;
      end

      // A slot coinciding with cfg_en falling still consumes din and steps the LFSR
      if (state == SEED) begin
        toggle    <= 1'b0;
        underflow <= 1'b0;
        dout      <= '0;
      end else if (slot) begin
        if (transfer) dout <= din;
        else          underflow <= 1'b1;
        if (cfg_mode == MODE_TOGGLE) toggle <= ~toggle;
      end

      if (!cfg_en) begin
        r <= '0;
      end else if (slot) begin
        case (cfg_mode)
          MODE_OFF:    r <= '0;
          MODE_TOGGLE: r <= {NSB{~toggle}};
          default:     r <= lfsr_q_next[NSB-1:0];
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ef_smsdac_mse_ctrl.sv
// tb/tb_ef_smsdac_mse_ctrl.sv - directed self-checking bench for ef_smsdac_mse_ctrl
module tb_ef_smsdac_mse_ctrl;

  localparam int NSB   = 7;
  localparam int DW    = 4;
  localparam int DIV_W = 8;

  logic             clk = 1'b0;
  logic             rst_b;
  logic             cfg_en;
  logic [1:0]       cfg_mode;
  logic [DIV_W-1:0] cfg_div;
  logic [15:0]      cfg_seed;
  logic [DW-1:0]    din;
  logic             din_valid;
  logic             din_ready;
  logic [DW-1:0]    dout;
  logic [NSB-1:0]   r;
  logic             sample_en;
  logic             sb_rst_b;
  logic             underflow;

  int n_checks = 0;
  int n_fail   = 0;

  ef_smsdac_mse_ctrl #(.NSB(NSB), .DW(DW), .DIV_W(DIV_W)) dut (
    .clk       (clk),
    .rst_b     (rst_b),
    .cfg_en    (cfg_en),
    .cfg_mode  (cfg_mode),
    .cfg_div   (cfg_div),
    .cfg_seed  (cfg_seed),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .dout      (dout),
    .r         (r),
    .sample_en (sample_en),
    .sb_rst_b  (sb_rst_b),
    .underflow (underflow)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] ref_step(input logic [15:0] q);
    return {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic restart(input logic [15:0] seed, input logic [DIV_W-1:0] div, input logic [1:0] mode);
    cfg_en = 1'b0;
    tick();
    cfg_seed = seed;
    cfg_div  = div;
    cfg_mode = mode;
    cfg_en   = 1'b1;
    repeat (4) tick();
    check_val("restart_sb_rst_b", {31'd0, sb_rst_b}, 32'd1);
  endtask

  task automatic wait_slot(input string tag);
    int n = 0;
    while (!din_ready && n < 50) begin
      tick();
      n++;
    end
    check_val(tag, {31'd0, din_ready}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] m;
    int n;
    rst_b = 1'b0; cfg_en = 1'b0; cfg_mode = 2'b01; cfg_div = '0;
    cfg_seed = 16'h0001; din = '0; din_valid = 1'b0;
    repeat (2) tick();
    check_val("rst_dout", {28'd0, dout}, 32'd0);
    check_val("rst_r", {25'd0, r}, 32'd0);
    check_val("rst_sample_en", {31'd0, sample_en}, 32'd0);
    check_val("rst_din_ready", {31'd0, din_ready}, 32'd0);
    check_val("rst_sb_rst_b", {31'd0, sb_rst_b}, 32'd0);
    check_val("rst_underflow", {31'd0, underflow}, 32'd0);
    rst_b = 1'b1;
    tick();

    // Startup timing with cfg_div=3
    cfg_div = 8'd3; cfg_mode = 2'b01; cfg_seed = 16'hACE1; din_valid = 1'b1; cfg_en = 1'b1;
    tick();
    check_val("seed_sb_rst_b", {31'd0, sb_rst_b}, 32'd0);
    check_val("seed_din_ready", {31'd0, din_ready}, 32'd0);
    tick(); tick();
    check_val("flush_sb_rst_b", {31'd0, sb_rst_b}, 32'd0);
    tick();
    check_val("run_sb_rst_b", {31'd0, sb_rst_b}, 32'd1);
    n = 0;
    while (!din_ready && n < 20) begin tick(); n++; end
    check_val("first_slot_wait", n, 32'd3);
    din = 4'hA;
    tick();
    m = ref_step(16'hACE1);
    check_val("s1_sample_en", {31'd0, sample_en}, 32'd1);
    check_val("s1_dout", {28'd0, dout}, 32'hA);
    check_val("s1_r", {25'd0, r}, {25'd0, m[6:0]});
    check_val("s1_din_ready", {31'd0, din_ready}, 32'd0);
    tick();
    check_val("s1_pulse_end", {31'd0, sample_en}, 32'd0);
    n = 2;
    while (!din_ready && n < 20) begin tick(); n++; end
    check_val("slot_period", n, 32'd4);
    din = 4'h3;
    tick();
    m = ref_step(m);
    check_val("s2_r", {25'd0, r}, {25'd0, m[6:0]});
    check_val("s2_dout", {28'd0, dout}, 32'h3);

    // LFSR sequence, seed 1, every cycle a slot
    restart(16'h0001, 8'd0, 2'b01);
    m = 16'h0001;
    for (int i = 0; i < 100; i++) begin
      din = i[3:0];
      tick();
      m = ref_step(m);
      if (i == 0) check_val("lfsr_first_hand", {25'd0, r}, 32'h02);
      if (i == 2) check_val("lfsr_third_hand", {25'd0, r}, 32'h08);
      check_val("lfsr_r", {25'd0, r}, {25'd0, m[6:0]});
      check_val("lfsr_sample_en", {31'd0, sample_en}, 32'd1);
      if (i % 17 == 0) check_val("lfsr_dout", {28'd0, dout}, {28'd0, i[3:0]});
    end
    restart(16'h0000, 8'd0, 2'b01);
    m = 16'h0001;
    for (int i = 0; i < 20; i++) begin
      tick();
      m = ref_step(m);
      check_val("seed0_r", {25'd0, r}, {25'd0, m[6:0]});
    end

    // Mode sweep
    restart(16'h1234, 8'd0, 2'b00);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_val("mode00_r", {25'd0, r}, 32'd0);
    end
    restart(16'h0001, 8'd0, 2'b10);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_val("mode10_r", {25'd0, r}, (i % 2 == 0) ? 32'h7F : 32'h00);
    end
    restart(16'h0001, 8'd0, 2'b11);
    m = 16'h0001;
    for (int i = 0; i < 20; i++) begin
      tick();
      m = ref_step(m);
      check_val("mode11_r", {25'd0, r}, {25'd0, m[6:0]});
    end

    // Underflow
    restart(16'h0001, 8'd1, 2'b01);
    din_valid = 1'b1; din = 4'h9;
    wait_slot("uf_wait1");
    tick();
    check_val("uf_dout9", {28'd0, dout}, 32'h9);
    check_val("uf_clear", {31'd0, underflow}, 32'd0);
    din_valid = 1'b0; din = 4'h2;
    wait_slot("uf_wait2");
    tick();
    check_val("uf_dout_hold", {28'd0, dout}, 32'h9);
    check_val("uf_set", {31'd0, underflow}, 32'd1);
    check_val("uf_sample_en", {31'd0, sample_en}, 32'd1);
    din_valid = 1'b1; din = 4'h5;
    wait_slot("uf_wait3");
    tick();
    check_val("uf_dout5", {28'd0, dout}, 32'h5);
    check_val("uf_sticky", {31'd0, underflow}, 32'd1);
    cfg_en = 1'b0;
    tick();
    check_val("uf_hold_idle", {31'd0, underflow}, 32'd1);
    check_val("dout_hold_idle", {28'd0, dout}, 32'h5);
    cfg_en = 1'b1;
    tick(); tick();
    check_val("uf_seed_clear", {31'd0, underflow}, 32'd0);
    check_val("dout_seed_clear", {28'd0, dout}, 32'd0);

    // Disable between slots
    restart(16'h0001, 8'd3, 2'b01);
    wait_slot("dis_wait");
    tick();
    check_val("dis_r_before", {25'd0, r}, 32'h02);
    tick();
    cfg_en = 1'b0;
    tick();
    check_val("dis_sb_rst_b", {31'd0, sb_rst_b}, 32'd0);
    check_val("dis_r", {25'd0, r}, 32'd0);
    check_val("dis_sample_en", {31'd0, sample_en}, 32'd0);
    check_val("dis_din_ready", {31'd0, din_ready}, 32'd0);
    restart(16'h0001, 8'd3, 2'b01);
    wait_slot("reen_wait");
    tick();
    check_val("reen_r", {25'd0, r}, 32'h02);

    // Asynchronous reset mid-run
    restart(16'h0001, 8'd0, 2'b01);
    din = 4'h7;
    tick(); tick();
    @(posedge clk);
    #3 rst_b = 1'b0;
    #1;
    check_val("arst_r", {25'd0, r}, 32'd0);
    check_val("arst_dout", {28'd0, dout}, 32'd0);
    check_val("arst_sb_rst_b", {31'd0, sb_rst_b}, 32'd0);
    check_val("arst_sample_en", {31'd0, sample_en}, 32'd0);
    check_val("arst_din_ready", {31'd0, din_ready}, 32'd0);
    @(negedge clk);
    rst_b = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_val("arst_no_pulse", {31'd0, sample_en}, 32'd0);
    end
    tick();
    check_val("arst_first_sample", {31'd0, sample_en}, 32'd1);
    check_val("arst_first_r", {25'd0, r}, 32'h02);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
